// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds the FSM states, the owner tags and the holding-register layout.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

    localparam logic TAG_IF = 1'b0;
    localparam logic TAG_D  = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        tag;
    } hold_t;

    // Fetches are always full-word reads.
    function automatic hold_t fetch_hold(input logic [31:0] addr);
        hold_t h;
        h.addr  = addr;
        h.we    = 1'b0;
        h.be    = 4'hF;
        h.wdata = 32'h0;
        h.tag   = TAG_IF;
        return h;
    endfunction

    function automatic hold_t data_hold(input logic [31:0] addr, input logic we,
                                        input logic [3:0] be, input logic [31:0] wdata);
        hold_t h;
        h.addr  = addr;
        h.we    = we;
        h.be    = be;
        h.wdata = wdata;
        h.tag   = TAG_D;
        return h;
    endfunction

endpackage

// File: rtl/owner_tag_fifo.sv
// In-order FIFO of 1-bit owner tags for memory transactions in flight.
// Push and pop may coincide, including when full.
module owner_tag_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_push,
    input  logic i_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        o_empty = (cnt_q == '0);
        o_full  = (cnt_q == CntW'(DEPTH));
        o_head  = mem_q[rd_q];
        do_pop  = i_pop && !o_empty;
        // A push at full only fits because the head leaves in the same cycle.
        do_push = i_push && (!o_full || do_pop);

        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = i_data;
            wr_d        = ptr_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined single-port memory between instruction fetch and data access,
// data-first with a starvation override for fetch; responses are routed by owner tag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTST  = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic [31:0] i_d_addr,
    input  logic        i_d_we,
    input  logic [3:0]  i_d_be,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_err
);

    localparam int unsigned StW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    arb_state_e     state_q, state_d;
    hold_t          hold_q, hold_d;
    logic [StW-1:0] starve_q, starve_d;
    logic           err_q, err_d;

    logic fifo_full, fifo_empty, fifo_head;
    logic issuing, push, pop;
    logic if_win, capture;

    owner_tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  (hold_q.tag),
        .i_pop   (pop),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_head  (fifo_head)
    );

    always_comb begin
        issuing = (state_q == ST_ISSUE);
        if_win  = i_if_req && (!i_d_req || (starve_q == StW'(STARVE_LIM)));
        // Gating with reset keeps the grant pulses low while reset is held.
        capture = (state_q == ST_IDLE) && !fifo_full && (i_if_req || i_d_req) && !i_reset;
        push    = issuing && i_mem_gnt;
        pop     = i_mem_rvalid && !fifo_empty;
        err_d   = err_q || (i_mem_rvalid && fifo_empty);
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        starve_d = starve_q;
        unique case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_ISSUE;
                    if (if_win) begin
                        hold_d   = fetch_hold(i_if_addr);
                        starve_d = '0;
                    end else begin
                        hold_d = data_hold(i_d_addr, i_d_we, i_d_be, i_d_wdata);
                        if (!i_if_req) begin
                            starve_d = '0;
                        end else if (starve_q != StW'(STARVE_LIM)) begin
                            starve_d = starve_q + StW'(1);
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (i_mem_gnt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        o_if_gnt    = capture && if_win;
        o_d_gnt     = capture && !if_win;

        o_mem_req   = issuing;
        o_mem_addr  = issuing ? hold_q.addr  : '0;
        o_mem_we    = issuing ? hold_q.we    : 1'b0;
        o_mem_be    = issuing ? hold_q.be    : '0;
        o_mem_wdata = issuing ? hold_q.wdata : '0;

        o_if_rvalid = pop && (fifo_head == TAG_IF);
        o_d_rvalid  = pop && (fifo_head == TAG_D);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;

        o_busy      = issuing || !fifo_empty;
        o_err       = err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: scoreboard of expected grants, memory beats and
// response owners, followed by a directed store / reset-mid-issue sequence.
module tb_mem_port_arbiter;

    localparam int unsigned MaxOutst  = 2;
    localparam int unsigned StarveLim = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt, o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_d_req, i_d_we;
    logic [31:0] i_d_addr, i_d_wdata;
    logic [3:0]  i_d_be;
    logic        o_d_gnt, o_d_rvalid;
    logic [31:0] o_d_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_busy, o_err;

    mem_port_arbiter #(
        .MAX_OUTST  (MaxOutst),
        .STARVE_LIM (StarveLim)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .o_if_gnt     (o_if_gnt),
        .o_if_rvalid  (o_if_rvalid),
        .o_if_rdata   (o_if_rdata),
        .i_d_req      (i_d_req),
        .i_d_addr     (i_d_addr),
        .i_d_we       (i_d_we),
        .i_d_be       (i_d_be),
        .i_d_wdata    (i_d_wdata),
        .o_d_gnt      (o_d_gnt),
        .o_d_rvalid   (o_d_rvalid),
        .o_d_rdata    (o_d_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .o_mem_we     (o_mem_we),
        .o_mem_be     (o_mem_be),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Stimulus knobs (percentages and response delay range in cycles).
    int unsigned if_p, d_p, we_p, gnt_p, dmin, dmax;
    bit          run_rand = 1'b0;
    bit          mon_en   = 1'b0;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } resp_t;
    resp_t       pend[$];
    int unsigned cyc      = 0;
    int unsigned last_due = 0;
    logic        if_gnt_s = 1'b0;
    logic        d_gnt_s  = 1'b0;

    // Requesters and memory: drive on the falling edge, observe handshakes a little later.
    always @(negedge i_clk) begin
        cyc++;
        if (run_rand) begin
            if (if_gnt_s || !i_if_req) begin
                i_if_req  = ($urandom_range(99) < if_p);
                i_if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (d_gnt_s || !i_d_req) begin
                i_d_req   = ($urandom_range(99) < d_p);
                i_d_addr  = $urandom & 32'hFFFF_FFFC;
                i_d_we    = ($urandom_range(99) < we_p);
                i_d_be    = 4'($urandom);
                i_d_wdata = $urandom;
            end
            i_mem_gnt = ($urandom_range(99) < gnt_p);
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = $urandom;
            end
            #3;
            if_gnt_s = o_if_gnt;
            d_gnt_s  = o_d_gnt;
            if (o_mem_req && i_mem_gnt) begin
                resp_t r;
                r.due = cyc + $urandom_range(dmax, dmin);
                if (r.due <= last_due) r.due = last_due + 1;
                r.data = $urandom;
                last_due = r.due;
                pend.push_back(r);
            end
        end
    end

    // Reference model: at most one captured request waits for the memory, at most
    // MaxOutst accepted requests await responses, responses return in acceptance order.
    logic        held = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we, h_tag;
    logic [3:0]  h_be;
    int unsigned outst  = 0;
    int unsigned starve = 0;
    logic        own_q[$];
    int unsigned forced_wins = 0;
    int unsigned full_stalls = 0;

    always @(negedge i_clk) begin
        #2;
        if (mon_en) begin : mon
            logic cap_ok, e_if, e_d, tag;
            cap_ok = !held && (outst < MaxOutst);
            e_if   = cap_ok && i_if_req && (!i_d_req || starve == StarveLim);
            e_d    = cap_ok && i_d_req && !e_if;
            if (e_if && i_d_req) forced_wins++;
            if (!held && outst == MaxOutst && (i_if_req || i_d_req)) full_stalls++;

            chk("if_gnt", o_if_gnt, e_if);
            chk("d_gnt", o_d_gnt, e_d);
            chk("mem_req", o_mem_req, held);
            if (held) begin
                chk("mem_addr", o_mem_addr, h_addr);
                chk("mem_we", o_mem_we, h_we);
                chk("mem_be", o_mem_be, h_be);
                chk("mem_wdata", o_mem_wdata, h_wdata);
            end
            chk("busy", o_busy, held || outst != 0);
            chk("err", o_err, 1'b0);

            if (i_mem_rvalid) begin
                chk("resp_has_owner", own_q.size() != 0, 1'b1);
                tag = (own_q.size() != 0) ? own_q.pop_front() : 1'b0;
                chk("if_rvalid", o_if_rvalid, tag == 1'b0);
                chk("d_rvalid", o_d_rvalid, tag == 1'b1);
                chk("if_rdata", o_if_rdata, (tag == 1'b0) ? i_mem_rdata : 32'h0);
                chk("d_rdata", o_d_rdata, (tag == 1'b1) ? i_mem_rdata : 32'h0);
                if (outst > 0) outst--;
            end else begin
                chk("if_rvalid_idle", o_if_rvalid, 1'b0);
                chk("d_rvalid_idle", o_d_rvalid, 1'b0);
            end

            if (held && i_mem_gnt) begin
                own_q.push_back(h_tag);
                outst++;
                held = 1'b0;
            end
            if (e_if) begin
                held = 1'b1; h_tag = 1'b0; h_addr = i_if_addr;
                h_we = 1'b0; h_be = 4'hF; h_wdata = 32'h0;
                starve = 0;
            end else if (e_d) begin
                held = 1'b1; h_tag = 1'b1; h_addr = i_d_addr;
                h_we = i_d_we; h_be = i_d_be; h_wdata = i_d_wdata;
                if (!i_if_req) starve = 0;
                else if (starve < StarveLim) starve++;
            end
        end
    end

    task automatic phase(input int unsigned ip, input int unsigned dp, input int unsigned wp,
                         input int unsigned gp, input int unsigned lo, input int unsigned hi,
                         input int unsigned n);
        @(negedge i_clk);
        #1;
        if_p = ip; d_p = dp; we_p = wp; gnt_p = gp; dmin = lo; dmax = hi;
        repeat (n) @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1;
        i_if_req = 1'b0; i_if_addr = '0;
        i_d_req = 1'b0; i_d_addr = '0; i_d_we = 1'b0; i_d_be = '0; i_d_wdata = '0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        repeat (2) @(negedge i_clk);
        #1;
        i_if_req = 1'b1;
        i_d_req  = 1'b1;
        #1;
        chk("rst_if_gnt", o_if_gnt, 1'b0);
        chk("rst_d_gnt", o_d_gnt, 1'b0);
        chk("rst_mem_req", o_mem_req, 1'b0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_err", o_err, 1'b0);
        @(negedge i_clk);
        #1;
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        i_reset  = 1'b0;
        if_p = 0; d_p = 0; we_p = 0; gnt_p = 100; dmin = 2; dmax = 2;
        run_rand = 1'b1;
        mon_en   = 1'b1;

        phase(60, 0, 0, 100, 2, 2, 40);     // fetch only
        phase(100, 100, 0, 100, 1, 1, 80);  // both pending: starvation override
        phase(100, 100, 30, 100, 8, 12, 100); // slow memory: outstanding limit
        phase(50, 50, 40, 60, 1, 6, 600);   // everything random

        // Drain, then hand over to the directed sequence.
        phase(0, 0, 0, 100, 1, 1, 0);
        for (int i = 0; i < 300; i++) begin
            if (!o_busy && pend.size() == 0 && !i_if_req && !i_d_req) break;
            @(negedge i_clk);
        end
        chk("drained", o_busy, 1'b0);
        chk("starve_override_seen", forced_wins > 0, 1'b1);
        chk("outst_limit_seen", full_stalls > 0, 1'b1);
        @(negedge i_clk);
        #1;
        run_rand = 1'b0;
        mon_en   = 1'b0;

        // Store goes out unchanged and stays outstanding.
        i_mem_gnt = 1'b1; i_mem_rvalid = 1'b0; i_if_req = 1'b0;
        i_d_req = 1'b1; i_d_addr = 32'h800; i_d_we = 1'b1; i_d_be = 4'b0011;
        i_d_wdata = 32'hA5A5;
        #2;
        chk("st_gnt", o_d_gnt, 1'b1);
        @(negedge i_clk);
        #1;
        i_d_req = 1'b0;
        #2;
        chk("st_mem_req", o_mem_req, 1'b1);
        chk("st_mem_addr", o_mem_addr, 32'h800);
        chk("st_mem_we", o_mem_we, 1'b1);
        chk("st_mem_be", o_mem_be, 4'b0011);
        chk("st_mem_wdata", o_mem_wdata, 32'hA5A5);

        // Fetch captured while the store is outstanding; memory withholds its grant.
        @(negedge i_clk);
        #1;
        i_mem_gnt = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h100;
        #2;
        chk("f_gnt", o_if_gnt, 1'b1);
        @(negedge i_clk);
        #1;
        chk("f_mem_req", o_mem_req, 1'b1);
        chk("f_mem_addr", o_mem_addr, 32'h100);
        chk("f_mem_be", o_mem_be, 4'hF);

        // Reset in the middle of the issue.
        i_reset = 1'b1;
        #1;
        chk("mid_rst_mem_req", o_mem_req, 1'b0);
        chk("mid_rst_mem_addr", o_mem_addr, 32'h0);
        chk("mid_rst_mem_be", o_mem_be, 4'h0);
        chk("mid_rst_if_gnt", o_if_gnt, 1'b0);
        chk("mid_rst_busy", o_busy, 1'b0);
        @(negedge i_clk);
        #1;
        i_if_req = 1'b0;
        @(negedge i_clk);
        #1;
        i_reset = 1'b0;
        #1;
        chk("post_rst_err", o_err, 1'b0);
        @(negedge i_clk);
        #1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("stale_if_rvalid", o_if_rvalid, 1'b0);
        chk("stale_d_rvalid", o_d_rvalid, 1'b0);
        chk("stale_d_rdata", o_d_rdata, 32'h0);
        @(negedge i_clk);
        #1;
        i_mem_rvalid = 1'b0;
        #1;
        chk("stale_err", o_err, 1'b1);
        chk("stale_mem_req", o_mem_req, 1'b0);
        chk("stale_busy", o_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
